// File: rtl/rf_freq_sched.sv
// rf_freq_sched
// Multi-channel RF frequency scheduler. Frequency words for CH_NUM channels
// are queued in a command FIFO, divided by the constant DIV with a restoring
// sequential divider, parked in per-channel shadow registers, and committed
// to the parallel frequency pins only at CPI boundaries when the UART frame
// has finished.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_init, i_stop     asynchronous levels, synchronised internally
//   i_pre_cpi, i_cpi   single-cycle pulses: close load window / request commit
//   i_tx_over_flag     UART frame finished (commit gate)
//   i_rf_data/_ch/_vld push interface; o_rf_data_rdy = FIFO can accept
//   o_rf_freq          committed codes, channel k at [k*OUT_W +: OUT_W]
//   o_rf_freq_ctrl     per-channel latch pulse, CTRL_PULSE clocks long
//   o_busy             work outstanding (FIFO, divider, commit, pending)
//   o_drop_cnt         saturating count of rejected pushes
//   o_apply_cnt        wrapping count of executed commits
module rf_freq_sched #(
    parameter int CH_NUM     = 4,
    parameter int FREQ_W     = 16,
    parameter int OUT_W      = 10,
    parameter int DIV        = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int CTRL_PULSE = 4,
    parameter int CH_W       = $clog2(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_init,
    input  logic                     i_stop,
    input  logic                     i_pre_cpi,
    input  logic                     i_cpi,
    input  logic                     i_tx_over_flag,
    input  logic [FREQ_W-1:0]        i_rf_data,
    input  logic [CH_W-1:0]          i_rf_ch,
    input  logic                     i_rf_data_vld,
    output logic                     o_rf_data_rdy,
    output logic [CH_NUM*OUT_W-1:0]  o_rf_freq,
    output logic [CH_NUM-1:0]        o_rf_freq_ctrl,
    output logic                     o_busy,
    output logic [15:0]              o_drop_cnt,
    output logic [31:0]              o_apply_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = CH_W + FREQ_W;
    localparam int REM_W = $clog2(DIV) + 1;
    localparam int CNT_W = $clog2(FREQ_W + 1);
    localparam int PC_W  = $clog2(CTRL_PULSE + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DIV  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // Registers
    logic                    init_meta_q, init_sync_q, init_prev_q;
    logic                    stop_meta_q, stop_sync_q;
    state_t                  state_q, state_d;
    logic                    window_q, window_d;
    logic                    apply_req_q, apply_req_d;
    logic [ENT_W-1:0]        fifo_mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]        fifo_mem_d [FIFO_DEPTH];
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [FREQ_W-1:0]       div_dvd_q, div_dvd_d;
    logic [REM_W-1:0]        div_rem_q, div_rem_d;
    logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
    logic [CH_W-1:0]         div_ch_q, div_ch_d;
    logic [OUT_W-1:0]        shadow_q [CH_NUM];
    logic [OUT_W-1:0]        shadow_d [CH_NUM];
    logic [CH_NUM-1:0]       pending_q, pending_d;
    logic [CH_NUM*OUT_W-1:0] freq_q, freq_d;
    logic [PC_W-1:0]         pulse_cnt_q [CH_NUM];
    logic [PC_W-1:0]         pulse_cnt_d [CH_NUM];
    logic [CH_NUM-1:0]       ctrl_q, ctrl_d;
    logic                    rdy_q, rdy_d;
    logic                    busy_q, busy_d;
    logic [15:0]             drop_q, drop_d;
    logic [31:0]             apply_cnt_q, apply_cnt_d;

    // Combinational helpers
    logic                    init_rise_s;
    logic                    full_s, empty_s, run_like_s, ch_ok_s;
    logic                    push_s, pop_s, drop_s, commit_s;
    logic [ENT_W-1:0]        fifo_head_s;
    logic [REM_W-1:0]        trial_s, rem_next_s;
    logic                    ge_s, last_s, div_wr_s, over_s;
    logic [FREQ_W-1:0]       dvd_next_s;
    logic [OUT_W-1:0]        quot_s;
    logic [AW:0]             fill_next_s;

    assign o_rf_data_rdy  = rdy_q;
    assign o_rf_freq      = freq_q;
    assign o_rf_freq_ctrl = ctrl_q;
    assign o_busy         = busy_q;
    assign o_drop_cnt     = drop_q;
    assign o_apply_cnt    = apply_cnt_q;

    // Two-flop synchronisers for the asynchronous control levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_meta_q <= 1'b0;
            init_sync_q <= 1'b0;
            init_prev_q <= 1'b0;
            stop_meta_q <= 1'b0;
            stop_sync_q <= 1'b0;
        end else begin
            init_meta_q <= i_init;
            init_sync_q <= init_meta_q;
            init_prev_q <= init_sync_q;
            stop_meta_q <= i_stop;
            stop_sync_q <= stop_meta_q;
        end
    end

    // Push/pop qualification, divider step and commit decision.
    always_comb begin
        init_rise_s = init_sync_q && !init_prev_q;
        empty_s     = (wr_ptr_q == rd_ptr_q);
        full_s      = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(FIFO_DEPTH));
        run_like_s  = (state_q == ST_RUN) || (state_q == ST_DIV);
        ch_ok_s     = (int'(i_rf_ch) < CH_NUM);
        push_s      = i_rf_data_vld && !full_s && run_like_s && ch_ok_s;
        drop_s      = i_rf_data_vld && !push_s;
        pop_s       = (state_q == ST_RUN) && !empty_s && window_q && !stop_sync_q;
        fifo_head_s = fifo_mem_q[rd_ptr_q[AW-1:0]];

        // One restoring step: shift the next dividend bit into the remainder;
        // quotient bits shift into the bottom of the dividend register.
        trial_s    = (div_rem_q << 1) | REM_W'(div_dvd_q[FREQ_W-1]);
        ge_s       = (trial_s >= REM_W'(DIV));
        rem_next_s = ge_s ? (trial_s - REM_W'(DIV)) : trial_s;
        dvd_next_s = {div_dvd_q[FREQ_W-2:0], ge_s};
        last_s     = (div_cnt_q == CNT_W'(FREQ_W - 1));
        // A stop seen on the final step aborts the write as well.
        div_wr_s   = (state_q == ST_DIV) && last_s && !stop_sync_q;
        over_s     = ({{OUT_W{1'b0}}, dvd_next_s} > {{FREQ_W{1'b0}}, {OUT_W{1'b1}}});
        quot_s     = over_s ? {OUT_W{1'b1}} : OUT_W'(dvd_next_s);

        // The i_cpi cycle itself can commit when the UART is already idle.
        commit_s   = (apply_req_q || i_cpi) && i_tx_over_flag && (state_q != ST_STOP);
    end

    // Next-state logic for the scheduler FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (init_rise_s) state_d = ST_RUN;
                else             state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (stop_sync_q) state_d = ST_STOP;
                else if (pop_s)  state_d = ST_DIV;
                else             state_d = ST_RUN;
            end
            ST_DIV: begin
                if (stop_sync_q) state_d = ST_STOP;
                else if (last_s) state_d = ST_RUN;
                else             state_d = ST_DIV;
            end
            ST_STOP: begin
                if (!stop_sync_q) state_d = ST_IDLE;
                else              state_d = ST_STOP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for FIFO, divider, window, commit request and counters.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        div_dvd_d  = div_dvd_q;
        div_rem_d  = div_rem_q;
        div_cnt_d  = div_cnt_q;
        div_ch_d   = div_ch_q;

        if (state_q == ST_STOP) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_s) begin
                fifo_mem_d[wr_ptr_q[AW-1:0]] = {i_rf_ch, i_rf_data};
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end

        if (pop_s) begin
            div_dvd_d = fifo_head_s[FREQ_W-1:0];
            div_ch_d  = fifo_head_s[ENT_W-1:FREQ_W];
            div_rem_d = '0;
            div_cnt_d = '0;
        end else if (state_q == ST_DIV) begin
            div_dvd_d = dvd_next_s;
            div_rem_d = rem_next_s;
            div_cnt_d = last_s ? '0 : (div_cnt_q + CNT_W'(1));
        end else begin
            div_cnt_d = '0;
        end

        // A commit reopens the window even if pre_cpi arrives in the same cycle.
        if (commit_s)                                 window_d = 1'b1;
        else if ((state_q == ST_IDLE) && init_rise_s) window_d = 1'b1;
        else if (i_pre_cpi)                           window_d = 1'b0;
        else                                          window_d = window_q;

        // Extra i_cpi pulses while a request is waiting simply merge into it.
        if (state_q == ST_STOP) apply_req_d = 1'b0;
        else if (commit_s)      apply_req_d = 1'b0;
        else if (i_cpi)         apply_req_d = 1'b1;
        else                    apply_req_d = apply_req_q;

        if (drop_s && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        else                                drop_d = drop_q;

        if (commit_s) apply_cnt_d = apply_cnt_q + 32'd1;
        else          apply_cnt_d = apply_cnt_q;

        fill_next_s = wr_ptr_d - rd_ptr_d;
        rdy_d = (fill_next_s != (AW+1)'(FIFO_DEPTH)) &&
                ((state_d == ST_RUN) || (state_d == ST_DIV));
    end

    // Per-channel shadow, pending, output and latch-pulse updates.
    always_comb begin
        shadow_d    = shadow_q;
        pulse_cnt_d = pulse_cnt_q;
        pending_d   = pending_q;
        freq_d      = freq_q;
        ctrl_d      = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            // The output always takes the pre-existing shadow, so a divider
            // write landing in the commit cycle stays pending for the next CPI.
            if (div_wr_s && (div_ch_q == CH_W'(k))) begin
                shadow_d[k]  = quot_s;
                pending_d[k] = 1'b1;
            end else if (state_q == ST_STOP) begin
                pending_d[k] = 1'b0;
            end else if (commit_s) begin
                pending_d[k] = 1'b0;
            end else begin
                pending_d[k] = pending_q[k];
            end

            if (commit_s && pending_q[k]) begin
                freq_d[k*OUT_W +: OUT_W] = shadow_q[k];
                pulse_cnt_d[k] = PC_W'(CTRL_PULSE);
            end else if (pulse_cnt_q[k] != '0) begin
                pulse_cnt_d[k] = pulse_cnt_q[k] - PC_W'(1);
            end else begin
                pulse_cnt_d[k] = pulse_cnt_q[k];
            end
            ctrl_d[k] = (pulse_cnt_d[k] != '0);
        end

        busy_d = (wr_ptr_d != rd_ptr_d) || (state_d == ST_DIV) ||
                 apply_req_d || (|pending_d);
    end

    // Main state register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            window_q    <= 1'b0;
            apply_req_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            div_dvd_q   <= '0;
            div_rem_q   <= '0;
            div_cnt_q   <= '0;
            div_ch_q    <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                shadow_q[k]    <= '0;
                pulse_cnt_q[k] <= '0;
            end
            pending_q   <= '0;
            freq_q      <= '0;
            ctrl_q      <= '0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 16'd0;
            apply_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            apply_req_q <= apply_req_d;
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            div_dvd_q   <= div_dvd_d;
            div_rem_q   <= div_rem_d;
            div_cnt_q   <= div_cnt_d;
            div_ch_q    <= div_ch_d;
            shadow_q    <= shadow_d;
            pulse_cnt_q <= pulse_cnt_d;
            pending_q   <= pending_d;
            freq_q      <= freq_d;
            ctrl_q      <= ctrl_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
            apply_cnt_q <= apply_cnt_d;
        end
    end

endmodule

// File: tb/tb_rf_freq_sched.sv
// Directed bench for rf_freq_sched. Stimulus pushes the expected state of
// each commit into a scoreboard queue; a monitor pops and compares whenever
// o_apply_cnt advances. A second instance with CH_NUM=3 shares the inputs
// so an out-of-range channel index can be driven on a 2-bit port.
module tb_rf_freq_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init, stop, pre_cpi, cpi, tx_over, vld;
    logic [15:0] rf_data;
    logic [1:0]  rf_ch;

    logic        rdy, busy;
    logic [39:0] freq;
    logic [3:0]  ctrl;
    logic [15:0] drop;
    logic [31:0] apply;

    logic        rdy3, busy3;
    logic [29:0] freq3;
    logic [2:0]  ctrl3;
    logic [15:0] drop3;
    logic [31:0] apply3;

    typedef struct {
        logic [31:0] apply;
        logic [39:0] freq;
        logic [3:0]  ctrl;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [39:0] exp_freq = 40'd0;
    logic [39:0] prev_freq;
    logic [31:0] last_apply = 32'd0;

    always #5 clk = ~clk;

    rf_freq_sched #(.CH_NUM(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_init(init), .i_stop(stop),
        .i_pre_cpi(pre_cpi), .i_cpi(cpi), .i_tx_over_flag(tx_over),
        .i_rf_data(rf_data), .i_rf_ch(rf_ch), .i_rf_data_vld(vld),
        .o_rf_data_rdy(rdy), .o_rf_freq(freq), .o_rf_freq_ctrl(ctrl),
        .o_busy(busy), .o_drop_cnt(drop), .o_apply_cnt(apply)
    );

    rf_freq_sched #(.CH_NUM(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_init(init), .i_stop(stop),
        .i_pre_cpi(pre_cpi), .i_cpi(cpi), .i_tx_over_flag(tx_over),
        .i_rf_data(rf_data), .i_rf_ch(rf_ch), .i_rf_data_vld(vld),
        .o_rf_data_rdy(rdy3), .o_rf_freq(freq3), .o_rf_freq_ctrl(ctrl3),
        .o_busy(busy3), .o_drop_cnt(drop3), .o_apply_cnt(apply3)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [15:0] d);
        rf_ch   = ch;
        rf_data = d;
        vld     = 1'b1;
        tick(1);
        vld     = 1'b0;
    endtask

    task automatic pulse_cpi();
        cpi = 1'b1;
        tick(1);
        cpi = 1'b0;
    endtask

    task automatic pulse_pre();
        pre_cpi = 1'b1;
        tick(1);
        pre_cpi = 1'b0;
    endtask

    task automatic expect_commit(input logic [31:0] a, input logic [3:0] c);
        exp_t e;
        e.apply = a;
        e.freq  = exp_freq;
        e.ctrl  = c;
        sb_q.push_back(e);
    endtask

    // Monitor: every advance of o_apply_cnt is a commit to be scored.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_apply = apply;
        end else if (apply != last_apply) begin
            last_apply = apply;
            if (sb_q.size() == 0) begin
                check("unexpected_commit", 64'(apply), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("commit_apply_cnt", 64'(apply), 64'(e.apply));
                check("commit_freq", 64'(freq), 64'(e.freq));
                check("commit_ctrl", 64'(ctrl), 64'(e.ctrl));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; init = 1'b0; stop = 1'b0; pre_cpi = 1'b0; cpi = 1'b0;
        tx_over = 1'b0; vld = 1'b0; rf_data = 16'd0; rf_ch = 2'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_freq", 64'(freq), 64'(0));
        check("rst_ctrl", 64'(ctrl), 64'(0));
        check("rst_rdy", 64'(rdy), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_drop", 64'(drop), 64'(0));
        check("rst_apply", 64'(apply), 64'(0));
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Scenario 1: basic commit of ch2 = 5000/10.
        init = 1'b1;
        tick(5);
        @(negedge clk);
        check("s1_rdy_after_init", 64'(rdy), 64'(1));
        tick(0);
        @(posedge clk); #1;
        push(2'd2, 16'd5000);
        tick(20);
        pulse_pre();
        tx_over = 1'b1;
        exp_freq[20 +: 10] = 10'd500;
        expect_commit(32'd1, 4'b0100);
        pulse_cpi();
        tick(3);
        @(negedge clk);
        check("s1_ctrl_4th_cycle", 64'(ctrl), 64'(4'b0100));
        @(negedge clk);
        check("s1_ctrl_ended", 64'(ctrl), 64'(0));
        @(posedge clk); #1;

        // Scenario 2: saturation of 20000/10 to 1023.
        push(2'd0, 16'd20000);
        tick(20);
        exp_freq[0 +: 10] = 10'd1023;
        expect_commit(32'd2, 4'b0001);
        pulse_cpi();
        tick(6);

        // Scenario 3: commit held off until tx_over rises; second cpi absorbed.
        push(2'd1, 16'd3000);
        tick(20);
        tx_over = 1'b0;
        prev_freq = exp_freq;
        exp_freq[10 +: 10] = 10'd300;
        expect_commit(32'd3, 4'b0010);
        pulse_cpi();
        tick(15);
        pulse_cpi();
        tick(15);
        @(negedge clk);
        check("s3_gated_apply", 64'(apply), 64'(2));
        check("s3_gated_freq", 64'(freq), 64'(prev_freq));
        @(posedge clk); #1;
        tx_over = 1'b1;
        @(negedge clk);
        check("s3_not_before_edge", 64'(apply), 64'(2));
        @(posedge clk); #1;
        tick(5);
        check("s3_no_double_count", 64'(apply), 64'(3));

        // Scenario 4: window closed, 10 pushes into an 8-deep FIFO.
        pulse_pre();
        for (int i = 0; i < 10; i++) begin
            rf_ch   = 2'(i % 4);
            rf_data = 16'(100 * (i + 1));
            vld     = 1'b1;
            @(negedge clk);
            if (i == 7) check("s4_rdy_before_8th", 64'(rdy), 64'(1));
            if (i == 8) check("s4_rdy_when_full", 64'(rdy), 64'(0));
            @(posedge clk); #1;
        end
        vld = 1'b0;
        tick(1);
        check("s4_drop_cnt", 64'(drop), 64'(2));
        check("s4_rdy_full", 64'(rdy), 64'(0));
        check("s4_busy", 64'(busy), 64'(1));

        // Scenario 5: empty commit opens the window, then stop mid-divide.
        expect_commit(32'd4, 4'b0000);
        pulse_cpi();
        tick(6);
        stop = 1'b1;
        tick(6);
        check("s5_flushed_busy", 64'(busy), 64'(0));
        check("s5_stop_rdy", 64'(rdy), 64'(0));
        pulse_cpi();
        tick(6);
        check("s5_freq_hold", 64'(freq), 64'(exp_freq));
        check("s5_no_ctrl", 64'(ctrl), 64'(0));
        stop = 1'b0;
        tick(6);
        check("s5_idle_rdy", 64'(rdy), 64'(0));
        push(2'd0, 16'd700);
        tick(1);
        check("s5_idle_push_drop", 64'(drop), 64'(3));
        init = 1'b0;
        tick(3);
        init = 1'b1;
        tick(5);
        check("s5_rearm_rdy", 64'(rdy), 64'(1));

        // Channel index out of range on the 3-channel instance only.
        push(2'd3, 16'd1234);
        tick(20);
        check("bad_ch_drop", 64'(drop3), 64'(4));
        check("good_ch_no_drop", 64'(drop), 64'(3));

        // Scenario 6: asynchronous reset in the middle of the ch3 pulse.
        exp_freq[30 +: 10] = 10'd123;
        expect_commit(32'd5, 4'b1000);
        pulse_cpi();
        tick(1);
        check("s6_pulse_active", 64'(ctrl), 64'(4'b1000));
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_ctrl", 64'(ctrl), 64'(0));
        check("s6_async_freq", 64'(freq), 64'(0));
        check("s6_async_apply", 64'(apply), 64'(0));
        check("s6_async_drop", 64'(drop), 64'(0));
        #20;
        rst_n = 1'b1;
        tick(2);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
